// File: rtl/serial_read_response_engine.sv
// Receive side of a serial read stream: filters responses by cu_id, checks
// offset order, buffers accepted beats in a FIFO and reports done/error.
//
// Ports:
//   ap_clk, ap_rst_n        clock, async active-low reset
//   config_*                transfer setup handshake (accepted in IDLE)
//   resp_in_*               response beats from the memory layer
//   data_out_*              FIFO head, first-word fall-through
//   resp_count, done, error status towards the engine controller
module serial_read_response_engine #(
    parameter int ENGINE_ID     = 0,
    parameter int COUNTER_WIDTH = 32,
    parameter int CU_ID_WIDTH   = 8,
    parameter int DATA_WIDTH    = 512,
    parameter int FIFO_DEPTH    = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     config_valid,
    output logic                     config_ready,
    input  logic [COUNTER_WIDTH-1:0] config_start_read,
    input  logic [COUNTER_WIDTH-1:0] config_end_read,
    input  logic [COUNTER_WIDTH-1:0] config_stride,
    input  logic                     config_decrement,
    input  logic                     resp_in_valid,
    output logic                     resp_in_ready,
    input  logic [CU_ID_WIDTH-1:0]   resp_in_cu_id,
    input  logic [COUNTER_WIDTH-1:0] resp_in_address_offset,
    input  logic [DATA_WIDTH-1:0]    resp_in_data,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic [DATA_WIDTH-1:0]    data_out_data,
    output logic [COUNTER_WIDTH-1:0] data_out_offset,
    output logic [COUNTER_WIDTH-1:0] resp_count,
    output logic                     done,
    output logic                     error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Two slots of margin: ready is registered, so one more beat can land
    // after the count crosses the limit.
    localparam logic [CW-1:0] AF_LIMIT = CW'(FIFO_DEPTH - 3);
    localparam logic [CU_ID_WIDTH-1:0] MY_ID = CU_ID_WIDTH'(ENGINE_ID);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BUSY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [COUNTER_WIDTH-1:0] start_q, end_q, stride_q;
    logic                     dec_q;
    logic [COUNTER_WIDTH-1:0] exp_q, exp_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     done_q, cfg_rdy_q, in_rdy_q;

    logic [DATA_WIDTH-1:0]    mem_data_q [FIFO_DEPTH];
    logic [COUNTER_WIDTH-1:0] mem_off_q  [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            fifo_cnt_q, fifo_cnt_d;

    logic cfg_take, beat_acc, push, pop;

    assign cfg_take = (state_q == S_IDLE) && config_valid;
    assign beat_acc = (state_q == S_BUSY) && resp_in_valid && in_rdy_q;
    // Foreign beats are consumed by the handshake but never pushed.
    assign push     = beat_acc && (resp_in_cu_id == MY_ID);
    assign pop      = (fifo_cnt_q != '0) && data_out_ready;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (config_valid) begin
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                exp_d   = start_q;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (push) begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                    if (resp_in_address_offset != exp_q) begin
                        err_d = 1'b1;
                    end
                    exp_d = dec_q ? exp_q - stride_q : exp_q + stride_q;
                    // Termination keys off the expected offset, not the
                    // offset carried by the beat.
                    if (exp_q == end_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        unique case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= '0;
            end_q      <= '0;
            stride_q   <= '0;
            dec_q      <= 1'b0;
            exp_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cfg_rdy_q  <= 1'b1;
            in_rdy_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            fifo_cnt_q <= fifo_cnt_d;
            cfg_rdy_q  <= (state_d == S_IDLE);
            in_rdy_q   <= (state_d == S_BUSY) && (fifo_cnt_d <= AF_LIMIT);
            done_q     <= (state_d == S_DONE);
            if (cfg_take) begin
                start_q  <= config_start_read;
                end_q    <= config_end_read;
                stride_q <= config_stride;
                dec_q    <= config_decrement;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= resp_in_data;
            mem_off_q[wr_ptr_q]  <= resp_in_address_offset;
        end
    end

    assign config_ready    = cfg_rdy_q;
    assign resp_in_ready   = in_rdy_q;
    assign data_out_valid  = (fifo_cnt_q != '0);
    assign data_out_data   = mem_data_q[rd_ptr_q];
    assign data_out_offset = mem_off_q[rd_ptr_q];
    assign resp_count      = cnt_q;
    assign done            = done_q;
    assign error           = err_q;

endmodule

// File: tb/tb_serial_read_response_engine.sv
// Self-checking bench for serial_read_response_engine: queue-based model
// compared every cycle, plus directed literal expectations.
module tb_serial_read_response_engine;

    localparam int EID   = 5;
    localparam int CW    = 32;
    localparam int IW    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 32;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b1;
    logic          config_valid;
    logic          config_ready;
    logic [CW-1:0] config_start_read;
    logic [CW-1:0] config_end_read;
    logic [CW-1:0] config_stride;
    logic          config_decrement;
    logic          resp_in_valid;
    logic          resp_in_ready;
    logic [IW-1:0] resp_in_cu_id;
    logic [CW-1:0] resp_in_address_offset;
    logic [DW-1:0] resp_in_data;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [DW-1:0] data_out_data;
    logic [CW-1:0] data_out_offset;
    logic [CW-1:0] resp_count;
    logic          done;
    logic          error;

    serial_read_response_engine #(
        .ENGINE_ID    (EID),
        .COUNTER_WIDTH(CW),
        .CU_ID_WIDTH  (IW),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .ap_clk                (ap_clk),
        .ap_rst_n              (ap_rst_n),
        .config_valid          (config_valid),
        .config_ready          (config_ready),
        .config_start_read     (config_start_read),
        .config_end_read       (config_end_read),
        .config_stride         (config_stride),
        .config_decrement      (config_decrement),
        .resp_in_valid         (resp_in_valid),
        .resp_in_ready         (resp_in_ready),
        .resp_in_cu_id         (resp_in_cu_id),
        .resp_in_address_offset(resp_in_address_offset),
        .resp_in_data          (resp_in_data),
        .data_out_valid        (data_out_valid),
        .data_out_ready        (data_out_ready),
        .data_out_data         (data_out_data),
        .data_out_offset       (data_out_offset),
        .resp_count            (resp_count),
        .done                  (done),
        .error                 (error)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [CW-1:0] o);
        return {~o, o ^ 32'h5A5A_1234};
    endfunction

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_SETUP, P_BUSY, P_DRAIN, P_DONE} ph_t;
    ph_t           m_ph = P_IDLE;
    logic [DW-1:0] m_dq[$];
    logic [CW-1:0] m_oq[$];
    logic [CW-1:0] m_exp = '0, m_start = '0, m_end = '0, m_stride = '0;
    logic          m_dec = 1'b0;
    int unsigned   m_cnt = 0;
    logic          m_err = 1'b0;

    always @(posedge ap_clk or negedge ap_rst_n) begin : model
        int   sz;
        logic acc, last;
        if (!ap_rst_n) begin
            m_ph = P_IDLE;
            m_dq.delete();
            m_oq.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            sz  = m_oq.size();
            acc = (m_ph == P_BUSY) && (sz <= DEPTH - 3) && resp_in_valid
                  && (resp_in_cu_id == IW'(EID));
            if (sz != 0 && data_out_ready) begin
                void'(m_dq.pop_front());
                void'(m_oq.pop_front());
            end
            case (m_ph)
                P_IDLE: if (config_valid) begin
                    m_start  = config_start_read;
                    m_end    = config_end_read;
                    m_stride = config_stride;
                    m_dec    = config_decrement;
                    m_cnt    = 0;
                    m_err    = 1'b0;
                    m_ph     = P_SETUP;
                end
                P_SETUP: begin
                    m_exp = m_start;
                    m_ph  = P_BUSY;
                end
                P_BUSY: if (acc) begin
                    m_dq.push_back(resp_in_data);
                    m_oq.push_back(resp_in_address_offset);
                    m_cnt++;
                    if (resp_in_address_offset != m_exp) m_err = 1'b1;
                    last  = (m_exp == m_end);
                    m_exp = m_dec ? m_exp - m_stride : m_exp + m_stride;
                    if (last) m_ph = P_DRAIN;
                end
                P_DRAIN: if (sz == 0) m_ph = P_DONE;
                P_DONE:  m_ph = P_IDLE;
                default: m_ph = P_IDLE;
            endcase
        end
    end

    always @(negedge ap_clk) begin
        if ($time > 2) begin
            chk("config_ready", config_ready, m_ph == P_IDLE);
            chk("resp_in_ready", resp_in_ready,
                (m_ph == P_BUSY) && (m_oq.size() <= DEPTH - 3));
            chk("data_out_valid", data_out_valid, m_oq.size() != 0);
            if (m_oq.size() != 0) begin
                chk("data_out_data", data_out_data, m_dq[0]);
                chk("data_out_offset", data_out_offset, m_oq[0]);
            end
            chk("resp_count", resp_count, m_cnt);
            chk("error", error, m_err);
            chk("done", done, m_ph == P_DONE);
        end
    end

    // ---------------- monitors ----------------
    logic [CW-1:0] pops[$];
    int            done_cnt = 0;

    always @(posedge ap_clk) begin
        if (ap_rst_n && data_out_valid && data_out_ready)
            pops.push_back(data_out_offset);
        if (ap_rst_n && done)
            done_cnt++;
        if (ap_rst_n && dut.push && !dut.pop
            && dut.fifo_cnt_q == 6'(DEPTH)) begin
            errors++;
            $display("FAIL fifo_overflow: got write at count %0d", DEPTH);
        end
    end

    // ---------------- drivers ----------------
    task automatic do_cfg(input logic [CW-1:0] s, input logic [CW-1:0] e,
                          input logic [CW-1:0] st, input logic d);
        int n = 0;
        config_start_read = s;
        config_end_read   = e;
        config_stride     = st;
        config_decrement  = d;
        config_valid      = 1'b1;
        while (!config_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk("cfg_wait_ok", n < 100, 1);
        @(negedge ap_clk);
        config_valid = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] cu, input logic [CW-1:0] off);
        int n = 0;
        resp_in_cu_id          = cu;
        resp_in_address_offset = off;
        resp_in_data           = mk(off);
        resp_in_valid          = 1'b1;
        while (!resp_in_ready && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        chk("send_wait_ok", n < 200, 1);
        @(negedge ap_clk);
        resp_in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        chk("done_wait_ok", n < 200, 1);
        repeat (3) @(negedge ap_clk);
        chk("done_pulses", done_cnt, target);
    endtask

    // ---------------- directed tests ----------------
    initial begin : stim
        logic [CW-1:0] t2e [5];
        logic [CW-1:0] t5e [4];
        int            k, d0;
        logic          acc;
        t2e = '{32'h40, 32'h30, 32'h20, 32'h10, 32'h00};
        t5e = '{32'd0, 32'd2, 32'd1, 32'd3};

        config_valid = 0; config_start_read = 0; config_end_read = 0;
        config_stride = 0; config_decrement = 0;
        resp_in_valid = 0; resp_in_cu_id = 0;
        resp_in_address_offset = 0; resp_in_data = 0;
        data_out_ready = 1;

        #1 ap_rst_n = 1'b0;
        #2;
        chk("rst_config_ready", config_ready, 1);
        chk("rst_resp_in_ready", resp_in_ready, 0);
        chk("rst_data_out_valid", data_out_valid, 0);
        chk("rst_resp_count", resp_count, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // ascending 0..3
        pops.delete();
        do_cfg(0, 3, 1, 0);
        for (int i = 0; i < 4; i++) send(IW'(EID), CW'(i));
        wait_done(1);
        chk("t1_pops", pops.size(), 4);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            chk("t1_offset", pops[i], i);
        chk("t1_count", resp_count, 4);
        chk("t1_error", error, 0);

        // descending 0x40..0x00
        pops.delete();
        do_cfg(32'h40, 32'h00, 32'h10, 1);
        for (int i = 0; i < 5; i++) send(IW'(EID), t2e[i]);
        wait_done(2);
        chk("t2_pops", pops.size(), 5);
        for (int i = 0; i < 5 && i < pops.size(); i++)
            chk("t2_offset", pops[i], t2e[i]);
        chk("t2_count", resp_count, 5);

        // backpressure: FIFO stops at 30
        pops.delete();
        data_out_ready = 0;
        do_cfg(0, 39, 1, 0);
        k = 0;
        for (int c = 0; c < 45; c++) begin
            resp_in_cu_id          = IW'(EID);
            resp_in_address_offset = CW'(k);
            resp_in_data           = mk(CW'(k));
            resp_in_valid          = 1'b1;
            acc = resp_in_ready;
            @(negedge ap_clk);
            if (acc) k++;
        end
        resp_in_valid = 0;
        chk("t3_fill", k, 30);
        chk("t3_ready_low", resp_in_ready, 0);
        chk("t3_valid", data_out_valid, 1);
        data_out_ready = 1;
        for (int i = 30; i < 40; i++) send(IW'(EID), CW'(i));
        wait_done(3);
        chk("t3_pops", pops.size(), 40);
        for (int i = 0; i < 40 && i < pops.size(); i++)
            chk("t3_offset", pops[i], i);
        chk("t3_count", resp_count, 40);

        // foreign cu_id interleaved
        pops.delete();
        do_cfg(0, 3, 1, 0);
        send(IW'(EID), 0);
        send(IW'(EID + 1), 32'h99);
        send(IW'(EID), 1);
        send(IW'(EID + 1), 1);
        send(IW'(EID), 2);
        send(IW'(EID + 1), 7);
        send(IW'(EID), 3);
        wait_done(4);
        chk("t4_count", resp_count, 4);
        chk("t4_pops", pops.size(), 4);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            chk("t4_offset", pops[i], i);
        chk("t4_error", error, 0);

        // out-of-order offsets
        pops.delete();
        do_cfg(0, 3, 1, 0);
        send(IW'(EID), 0);
        chk("t5_err_after1", error, 0);
        send(IW'(EID), 2);
        chk("t5_err_after2", error, 1);
        send(IW'(EID), 1);
        send(IW'(EID), 3);
        wait_done(5);
        chk("t5_pops", pops.size(), 4);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            chk("t5_offset", pops[i], t5e[i]);
        chk("t5_count", resp_count, 4);
        repeat (4) @(negedge ap_clk);
        chk("t5_err_sticky", error, 1);

        // reset mid-transfer
        do_cfg(0, 9, 1, 0);
        chk("t6_err_cleared", error, 0);
        data_out_ready = 0;
        for (int i = 0; i < 5; i++) send(IW'(EID), CW'(i));
        chk("t6_buffered", resp_count, 5);
        chk("t6_valid", data_out_valid, 1);
        d0 = done_cnt;
        #2 ap_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", data_out_valid, 0);
        chk("t6_rst_count", resp_count, 0);
        chk("t6_rst_cfg_ready", config_ready, 1);
        chk("t6_rst_in_ready", resp_in_ready, 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        data_out_ready = 1;
        repeat (4) @(negedge ap_clk);
        chk("t6_no_done", done_cnt, d0);

        // single beat, start == end
        pops.delete();
        do_cfg(7, 7, 0, 0);
        send(IW'(EID), 7);
        wait_done(d0 + 1);
        chk("t7_count", resp_count, 1);
        chk("t7_pops", pops.size(), 1);

        // modular wrap-around
        pops.delete();
        do_cfg(32'hFFFF_FFE0, 32'h10, 32'h10, 0);
        send(IW'(EID), 32'hFFFF_FFE0);
        send(IW'(EID), 32'hFFFF_FFF0);
        send(IW'(EID), 32'h0);
        send(IW'(EID), 32'h10);
        wait_done(d0 + 2);
        chk("t8_count", resp_count, 4);
        chk("t8_error", error, 0);

        repeat (3) @(negedge ap_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
